i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Parallel-to-serial I2S transmitter that sits directly downstream of the audio clock generator. It accepts stereo sample pairs over a valid/ready handshake and buffers one pair. It shifts each pair out on `sdata`, MSB first, with I2S one-bit delay, aligned to the generator's decrementing frame counter. `sdata` changes on the `bclk` falling edge and is stable for codec sampling on `bclk` rising.

## Interface
- `DATA_W`, 24: sample width in bits; legal range 1..31.

- `mclk`  in  1: master clock; the same clock that drives the clock generator.
- `rst`  in  1: asynchronous, active-high reset.
- `cnt256_n`  in  8: decrementing frame counter from the clock generator; `bclk = ~cnt256_n[1]`, `wclk = cnt256_n[7]`.
- `s_l_data`  in  DATA_W: left sample, two's complement.
- `s_r_data`  in  DATA_W: right sample.
- `s_valid`  in  1: pair on `s_l_data`/`s_r_data` is valid.
- `s_ready`  out  1: one-entry buffer is empty.
- `sdata`  out  1: I2S serial data.
- `underrun`  out  1: one-cycle pulse when a frame starts with no buffered pair.
- `underrun_cnt`  out  16: saturating count of underrun frames.

## Operation
- Frame structure: 256 mclk, 64 bclk.
  - Left half is `cnt256_n` 127..0 (`wclk`=0).
  - Right half is 255..128 (`wclk`=1).
  - Each half holds 32 bit periods; a period is 4 mclk.
- Buffer: one entry `{buf_l, buf_r}` plus a `buf_full` flag.
  - `s_ready = ~buf_full`.
  - A transfer occurs on an mclk edge where `s_valid && s_ready`; it captures both samples and sets `buf_full`.
- Load edge: the mclk edge where the sampled `cnt256_n == 8'd128`, i.e. the right→left frame boundary.
  - If `buf_full`: copy the buffer to `{frm_l, frm_r}` and clear `buf_full`.
  - Otherwise: load zeros into `{frm_l, frm_r}`, pulse `underrun` for 1 cycle, and increment `underrun_cnt`, saturating at 16'hFFFF.
  - An edge that both accepts a pair into an empty buffer and is the load edge counts as an underrun. The accepted pair stays buffered and plays in the next frame.
  - A transfer cannot coincide with a load from a full buffer, because `s_ready` is 0 then.
- Shift edge: any mclk edge where the sampled `cnt256_n[1:0] == 2'b00`.
  - Let `n = cnt256_n - 1` (mod 256), `p = 31 - n[6:2]` (period index 0..31), and `word = n[7] ? frm_r : frm_l`.
  - `sdata <= (p >= 1 && p <= DATA_W) ? word[DATA_W - p] : 1'b0`.
  - Period 0 (I2S delay) and the trailing periods DATA_W+1..31 carry 0.
- `sdata` holds its value between shift edges.
- `frm_l`/`frm_r` change only on load edges. A pair is therefore never torn across a frame.

## Timing
- Reset values: `sdata`=0, `s_ready`=1, `underrun`=0, `underrun_cnt`=0.
  - Internally `buf_full`=0 and `frm_l`=`frm_r`=0.
- Reset is asynchronous assert. Deassertion is sampled on `mclk`.
- Reset mid-frame: the output holds 0 until normal shifting resumes. The first real frame starts at the next load edge, which counts as an underrun if no pair arrived by then.
- Frame timing relative to the load edge L (`cnt256_n` sampled 128):
  - Left MSB appears at L+4 mclk (sampled `cnt256_n`=124).
  - Left LSB appears at L+4·DATA_W.
  - Right MSB appears at L+132.
  - Right LSB appears at L+128+4·DATA_W.
- Each `sdata` change coincides with a `bclk` falling edge. `sdata` is stable across the following `bclk` rising edge, i.e. the update after sampled `cnt256_n[1:0]`=2.
- Handshake: `s_ready` returns to 1 on the cycle after the load edge. Sustained throughput is exactly one pair per 256 mclk.
- Minimum latency is 4 mclk: a pair accepted while the buffer is empty, at or before sampled `cnt256_n`=129, reaches `sdata` MSB 4 mclk after the next load edge.

## Test plan
1. Reset: assert `rst` mid-frame with the buffer full → all outputs go to reset values at once; `s_ready`=1 immediately; `underrun_cnt` reads 0.
2. Single pair: L=24'hA5F00F, R=24'h5A0FF0 accepted at `cnt256_n`=200 → sample `sdata` at `bclk` rising; left half gives 0, 101001011111000000001111, then 7 zeros; right half gives 0, 010110100000111111110000, then 7 zeros; `underrun` stays 0.
3. Backpressure: hold `s_valid`=1 with an incrementing pair sequence for 8 frames → `s_ready` drops after each accept and rises 1 cycle after each load edge; every pair is transmitted exactly once, in order; `underrun` is never asserted.
4. Underrun: no `s_valid` for 3 frames after reset → `underrun` pulses 3 times, each at `cnt256_n`=128; `underrun_cnt`=3; `sdata` stays constantly 0.
5. Boundary accept: offer a pair only on the load-edge cycle with the buffer empty → that frame underruns (`underrun_cnt`+1) and the pair plays in the following frame.
6. Saturation: force `underrun_cnt` to 16'hFFFE by hierarchical deposit, then leave 3 frames empty → the count stops at 16'hFFFF; `underrun` still pulses every frame.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//
// Parallel-to-serial I2S transmitter. Stereo sample pairs arrive over a
// valid/ready handshake into a one-entry buffer. At each right->left frame
// boundary the buffered pair (or silence, on underrun) is copied into the
// frame registers. It is then shifted out MSB first with the I2S one-bit
// delay. Frame alignment follows the clock generator's decrementing
// 256-mclk frame counter.
//
// Parameters:
//   DATA_W        sample width in bits (1..31)
//
// Ports:
//   mclk          master clock (same as the clock generator)
//   rst           asynchronous, active-high reset
//   cnt256_n      decrementing frame counter; bclk = ~cnt256_n[1],
//                 wclk = cnt256_n[7]
//   s_l_data      left sample, two's complement
//   s_r_data      right sample
//   s_valid       pair on s_l_data/s_r_data is valid
//   s_ready       one-entry buffer is empty
//   sdata         I2S serial data, updated on bclk falling edges
//   underrun      one-cycle pulse when a frame starts with no buffered pair
//   underrun_cnt  saturating count of underrun frames
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int DATA_W = 24
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [7:0]        cnt256_n,
  input  logic [DATA_W-1:0] s_l_data,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sdata,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic              buf_full;
  logic [DATA_W-1:0] frm_l;
  logic [DATA_W-1:0] frm_r;

  logic              load_edge;
  logic              shift_edge;
  logic              accept;
  logic [5:0]        per_n;
  logic [DATA_W-1:0] word;
  logic [31:0]       word_pad;

  assign load_edge  = (cnt256_n == 8'd128);
  assign shift_edge = (cnt256_n[1:0] == 2'b00);
  assign s_ready    = ~buf_full;
  assign accept     = s_valid & ~buf_full;

  // On a shift edge the low counter bits are 00, so (cnt256_n - 1)[7:2]
  // is simply cnt256_n[7:2] - 1: bit 5 selects the half, bits 4:0 the
  // position within it counted down from 31.
  assign per_n = cnt256_n[7:2] - 6'd1;
  assign word  = per_n[5] ? frm_r : frm_l;

  // The sample is left-aligned below a zero in bit 31. Indexing with the
  // down-counting position then yields the delay slot (bit 31), the sample
  // MSB..LSB, and trailing zeros without any range compare.
  assign word_pad = 32'(word) << (31 - DATA_W);

  // One-entry input buffer. A load from a full buffer and an accept are
  // mutually exclusive because s_ready is low whenever the buffer is full.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else if (load_edge && buf_full) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_l    <= s_l_data;
      buf_r    <= s_r_data;
      buf_full <= 1'b1;
    end
  end

  // Frame registers only change at the frame boundary, so a pair is never
  // split across frames. A pair accepted on the boundary edge itself was not
  // yet in the buffer, so that frame plays silence and counts as underrun.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      frm_l        <= '0;
      frm_r        <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (load_edge) begin
        if (buf_full) begin
          frm_l <= buf_l;
          frm_r <= buf_r;
        end else begin
          frm_l    <= '0;
          frm_r    <= '0;
          underrun <= 1'b1;
          if (underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sdata <= 1'b0;
    end else if (shift_edge) begin
      sdata <= word_pad[per_n[4:0]];
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2s_tx_serializer
//
// Self-checking bench for i2s_tx_serializer. The bench drives the frame
// counter itself. A reference model turns each accepted pair into the
// 64-slot bit sequence of one frame, or into a silent frame plus an
// underrun. It queues those slots, and a monitor pops one slot per bclk
// rising edge. Handshake and underrun outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_i2s_tx_serializer;

  localparam int DATA_W = 24;

  logic              mclk;
  logic              rst;
  logic [7:0]        cnt256_n;
  logic [DATA_W-1:0] s_l_data;
  logic [DATA_W-1:0] s_r_data;
  logic              s_valid;
  logic              s_ready;
  logic              sdata;
  logic              underrun;
  logic [15:0]       underrun_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic mon_en       = 1'b0;
  int   deposit_ask  = 0;
  int   deposit_done = 0;

  // Reference model state
  logic [DATA_W-1:0] pend_l[$];
  logic [DATA_W-1:0] pend_r[$];
  bit                bit_q[$];
  logic              exp_underrun = 1'b0;
  logic [15:0]       exp_cnt      = '0;
  bit                model_was_empty;
  bit                exp_bit;

  i2s_tx_serializer #(.DATA_W(DATA_W)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .cnt256_n     (cnt256_n),
    .s_l_data     (s_l_data),
    .s_r_data     (s_r_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .sdata        (sdata),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Free-running clock-generator frame counter, unaffected by rst
  initial begin
    cnt256_n = 8'd37;
    forever begin
      @(posedge mclk);
      #1 cnt256_n = cnt256_n - 8'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame layout per half: one delay slot, the sample MSB first, then zeros
  function automatic void pushHalf(input logic [DATA_W-1:0] s);
    bit_q.push_back(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) bit_q.push_back(s[i]);
    for (int i = DATA_W; i < 31; i++) bit_q.push_back(1'b0);
  endfunction

  function automatic void pushFrame(input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r);
    pushHalf(l);
    pushHalf(r);
  endfunction

  function automatic logic [63:0] frameOf(input logic [DATA_W-1:0] l,
                                          input logic [DATA_W-1:0] r);
    return {1'b0, l, {(31 - DATA_W){1'b0}}, 1'b0, r, {(31 - DATA_W){1'b0}}};
  endfunction

  // Reference model: buffer occupancy as a queue of at most one pair;
  // each frame boundary emits one frame of expected slots.
  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      pend_l.delete();
      pend_r.delete();
      bit_q.delete();
      exp_underrun = 1'b0;
      exp_cnt      = '0;
    end else begin
      if (deposit_ask != deposit_done) begin
        dut.underrun_cnt = 16'hFFFE;
        exp_cnt          = 16'hFFFE;
        deposit_done     = deposit_ask;
      end
      model_was_empty = (pend_l.size() == 0);
      exp_underrun    = 1'b0;
      if (cnt256_n == 8'd128) begin
        if (model_was_empty) begin
          pushFrame('0, '0);
          exp_underrun = 1'b1;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end else begin
          pushFrame(pend_l.pop_front(), pend_r.pop_front());
        end
      end
      if (s_valid && model_was_empty) begin
        pend_l.push_back(s_l_data);
        pend_r.push_back(s_r_data);
      end
    end
  end

  // Monitor: a current counter value with low bits 01 means the last sampled
  // value had low bits 10, i.e. bclk has just risen and sdata is mid-period.
  always @(negedge mclk) begin
    if (mon_en) begin
      checkOutput("s_ready", s_ready, (pend_l.size() == 0));
      checkOutput("underrun", underrun, exp_underrun);
      checkOutput("underrun_cnt", underrun_cnt, exp_cnt);
      if (cnt256_n[1:0] == 2'b01) begin
        if (bit_q.size() > 0) exp_bit = bit_q.pop_front();
        else exp_bit = 1'b0;
        checkOutput("sdata", sdata, exp_bit);
      end
    end
  end

  task automatic waitCnt(input logic [7:0] v);
    do @(negedge mclk); while (cnt256_n != v);
  endtask

  // Offer a pair for one cycle; the edge sampling counter value 'at' sees it
  task automatic applyStimulus(input logic [DATA_W-1:0] l,
                               input logic [DATA_W-1:0] r,
                               input logic [7:0] at);
    waitCnt(at);
    s_l_data = l;
    s_r_data = r;
    s_valid  = 1'b1;
    @(negedge mclk);
    s_valid  = 1'b0;
  endtask

  // Record the 64 bclk-rising samples of the frame following the next load
  task automatic captureFrame(output logic [63:0] f);
    f = '0;
    waitCnt(8'd127);
    repeat (64) begin
      do @(negedge mclk); while (cnt256_n[1:0] != 2'b01);
      f = {f[62:0], sdata};
    end
  endtask

  logic [63:0]       frame;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] l5;
  logic [DATA_W-1:0] r5;
  logic              will_accept;
  int                pulses;

  initial begin
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_l_data = '0;
    s_r_data = '0;
    repeat (5) @(posedge mclk);
    mon_en = 1'b1;
    @(negedge mclk);
    rst = 1'b0;

    $display("[TB] single pair");
    applyStimulus(24'hA5F00F, 24'h5A0FF0, 8'd200);
    captureFrame(frame);
    checkOutput("single_pair_frame", frame, frameOf(24'hA5F00F, 24'h5A0FF0));
    checkOutput("single_pair_no_underrun", underrun_cnt, 0);

    $display("[TB] reset mid-frame with buffer full");
    applyStimulus(24'hFFFFFF, 24'h123456, 8'd200);
    applyStimulus(24'h0F0F0F, 24'hF0F0F0, 8'd110);
    waitCnt(8'd100);
    @(posedge mclk);
    #1 checkOutput("pre_reset_sdata", sdata, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_sdata", sdata, 1'b0);
    checkOutput("reset_s_ready", s_ready, 1'b1);
    checkOutput("reset_underrun", underrun, 1'b0);
    checkOutput("reset_underrun_cnt", underrun_cnt, 0);
    repeat (3) @(negedge mclk);
    rst = 1'b0;

    $display("[TB] underrun for three frames");
    repeat (3) waitCnt(8'd127);
    checkOutput("underrun_cnt_3", underrun_cnt, 3);

    $display("[TB] backpressure");
    base        = DATA_W'($urandom);
    s_l_data    = base;
    s_r_data    = ~base;
    s_valid     = 1'b1;
    will_accept = s_ready;
    repeat (8 * 256) begin
      @(negedge mclk);
      if (will_accept) begin
        base     = base + 1'b1;
        s_l_data = base;
        s_r_data = ~base;
      end
      will_accept = s_ready;
    end
    s_valid = 1'b0;
    checkOutput("backpressure_no_underrun", underrun_cnt, 3);

    $display("[TB] boundary accept");
    l5 = DATA_W'($urandom);
    r5 = DATA_W'($urandom);
    applyStimulus(l5, r5, 8'd128);
    captureFrame(frame);
    checkOutput("boundary_frame", frame, frameOf(l5, r5));
    checkOutput("boundary_underrun_cnt", underrun_cnt, 4);

    $display("[TB] random traffic");
    repeat (6 * 256) begin
      @(negedge mclk);
      s_valid  = ($urandom_range(0, 2) == 0);
      s_l_data = DATA_W'($urandom);
      s_r_data = DATA_W'($urandom);
    end
    s_valid = 1'b0;
    repeat (2) waitCnt(8'd127);

    $display("[TB] counter saturation");
    waitCnt(8'd50);
    deposit_ask++;
    @(negedge mclk);
    checkOutput("sat_deposit", underrun_cnt, 16'hFFFE);
    pulses = 0;
    repeat (3 * 256) begin
      @(negedge mclk);
      if (underrun) pulses++;
    end
    checkOutput("sat_pulses", pulses, 3);
    checkOutput("sat_cnt", underrun_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
